// File: rtl/vga_frame_reader_if.sv
// Bundle between the frame reader, the VGA timing generator, the frame RAM
// read port and the capture side. The master is the frame reader. The slave
// is the surrounding system: timing generator, RAM and capture logic.
interface vga_frame_reader_if #(
  parameter int ADDR_W = 18
);
  logic [9:0]        xpos;
  logic [9:0]        ypos;
  logic              ptick;
  logic              frame_ready;
  logic              pattern_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_data;
  logic              rd_bank;
  logic              swap_ack;
  logic [7:0]        pixel_r;
  logic [7:0]        pixel_g;
  logic [7:0]        pixel_b;

  modport master (
    input  xpos, ypos, ptick, frame_ready, pattern_en, rd_data,
    output rd_addr, rd_bank, swap_ack, pixel_r, pixel_g, pixel_b
  );

  modport slave (
    output xpos, ypos, ptick, frame_ready, pattern_en, rd_data,
    input  rd_addr, rd_bank, swap_ack, pixel_r, pixel_g, pixel_b
  );
endinterface

// File: rtl/vga_frame_reader.sv
// Pixel source for a 640x480 VGA timing generator. It prefetches RGB565
// pixels two positions ahead from a double-buffered 320x240 frame RAM,
// upscales by 2 in both directions and expands the pixels to 8-bit RGB. It
// swaps the displayed bank at the end of the first vertical-blank line once
// the capture side reports a complete frame.
module vga_frame_reader #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SRC_W    = 320,
  parameter int SRC_H    = 240,
  parameter int ADDR_W   = 18
) (
  input  logic                clk,
  input  logic                reset,
  vga_frame_reader_if.master  bus
);
  localparam int IDX_W = ADDR_W - 1;

  typedef enum logic {IDLE, PENDING} state_t;

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_bank;
  logic              swap_ack;
  logic              v1;
  logic [2:0]        bar1;
  logic [15:0]       hold;
  logic [23:0]       pixel;

  logic [10:0]       fx_sum;
  logic [9:0]        fx;
  logic [9:0]        fy;
  logic [8:0]        row;
  logic [8:0]        col;
  logic [IDX_W-1:0]  idx;
  logic              fetch_valid;
  logic              swap_edge;

  // RGB565 to RGB888 by replicating the top bits into the low bits.
  function automatic logic [23:0] expand(input logic [15:0] w);
    return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
  endfunction

  // Colour bars are 128 pixels wide so the bar index is just fx[9:7].
  function automatic logic [15:0] bar_word(input logic [2:0] b);
    case (b)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hFFE0;
      3'd2:    return 16'h07FF;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hF81F;
      default: return 16'h0000;
    endcase
  endfunction

  // Fetch position is two pixels ahead, with wrap across lines and frames.
  // The row/column guards protect the RAM if the active area and the source
  // size are ever parameterised inconsistently.
  always_comb begin
    fx_sum = {1'b0, bus.xpos} + 11'd2;
    fx     = fx_sum[9:0];
    fy     = bus.ypos;
    if (fx_sum >= 11'(H_TOTAL)) begin
      fx = 10'(fx_sum - 11'(H_TOTAL));
      fy = bus.ypos + 10'd1;
    end
    if (fy == 10'(V_TOTAL))
      fy = '0;
    row = fy[9:1];
    col = fx[9:1];
    fetch_valid = (fx < 10'(H_ACTIVE)) && (fy < 10'(V_ACTIVE)) &&
                  (row < 9'(SRC_H)) && (col < 9'(SRC_W));
    idx = IDX_W'(row) * IDX_W'(SRC_W) + IDX_W'(col);
    swap_edge = bus.ptick && (bus.xpos == 10'(H_TOTAL - 1)) &&
                (bus.ypos == 10'(V_ACTIVE));
  end

  // Fetch pipeline: address and capture on ptick edges, output on the
  // off-tick edge so the generator's input register sees a stable value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr <= '0;
      v1      <= 1'b0;
      bar1    <= '0;
      hold    <= '0;
      pixel   <= '0;
    end else if (bus.ptick) begin
      if (fetch_valid)
        rd_addr <= {rd_bank, idx};
      v1   <= fetch_valid;
      bar1 <= fx[9:7];
      if (!v1)
        hold <= 16'h0000;
      else if (bus.pattern_en)
        hold <= bar_word(bar1);
      else
        hold <= bus.rd_data;
    end else begin
      pixel <= expand(hold);
    end
  end

  // Bank swap FSM. A frame_ready that arrives while a swap is pending is
  // absorbed. One that lands on the swap edge itself re-arms the FSM for the
  // next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rd_bank  <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      case (state)
        IDLE: if (bus.frame_ready) state <= PENDING;
        PENDING: begin
          if (swap_edge) begin
            rd_bank  <= ~rd_bank;
            swap_ack <= 1'b1;
            state    <= bus.frame_ready ? PENDING : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_addr  = rd_addr;
  assign bus.rd_bank  = rd_bank;
  assign bus.swap_ack = swap_ack;
  assign bus.pixel_r  = pixel[23:16];
  assign bus.pixel_g  = pixel[15:8];
  assign bus.pixel_b  = pixel[7:0];
endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader. The stimulus plays the timing
// generator and queues expected values tagged with the cycle on which they
// must hold. A separate monitor compares these on the falling edge.
module tb_vga_frame_reader;
  localparam int ADDR_W = 18;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  vga_frame_reader_if #(.ADDR_W(ADDR_W)) bus();
  vga_frame_reader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM model: word = low 16 bits of the address, unless overridden.
  logic        ovr_en;
  logic [15:0] ovr_word;
  always @(posedge clk) bus.rd_data <= ovr_en ? ovr_word : bus.rd_addr[15:0];

  typedef struct {int cyc; int sig; logic [31:0] val;} exp_t;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] act;
  int          b;

  function automatic logic [31:0] sample(input int s);
    case (s)
      0:       return {8'h0, bus.pixel_r, bus.pixel_g, bus.pixel_b};
      1:       return 32'(bus.rd_addr);
      2:       return {31'h0, bus.rd_bank};
      default: return {31'h0, bus.swap_ack};
    endcase
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      0:       return "pixel";
      1:       return "rd_addr";
      2:       return "rd_bank";
      default: return "swap_ack";
    endcase
  endfunction

  // Monitor: compare every queued expectation whose cycle has arrived.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        act = sample(sb[i].sig);
        if (sb[i].cyc < cyc || act !== sb[i].val) begin
          errors++;
          $display("FAIL %s cyc %0d: got %h expected %h",
                   sig_name(sb[i].sig), sb[i].cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int c, input int s, input logic [31:0] v);
    exp_t e;
    e.cyc = c; e.sig = s; e.val = v;
    sb.push_back(e);
  endtask

  // Fetch at xpos x+k shows on the pixel outputs between A(x+k+2) and B(x+k+2).
  task automatic pix_at(input int base, input int k, input logic [23:0] rgb);
    expect_at(base + 5 + 2*k, 0, {8'h0, rgb});
    expect_at(base + 6 + 2*k, 0, {8'h0, rgb});
  endtask

  // Address for the fetch at xpos x+k is visible after B(x+k).
  task automatic addr_at(input int base, input int k, input logic [31:0] a);
    expect_at(base + 2 + 2*k, 1, a);
    expect_at(base + 3 + 2*k, 1, a);
  endtask

  task automatic set_pos(input int x, input int y, output int base);
    @(negedge clk);
    bus.xpos = 10'(x); bus.ypos = 10'(y); bus.ptick = 1'b0; bus.frame_ready = 1'b0;
    base = cyc;
  endtask

  task automatic step(input logic fr);
    @(negedge clk);
    if (bus.ptick) begin
      bus.ptick = 1'b0;
      if (bus.xpos == 10'd799) begin
        bus.xpos = '0;
        bus.ypos = (bus.ypos == 10'd524) ? 10'd0 : bus.ypos + 10'd1;
      end else begin
        bus.xpos = bus.xpos + 10'd1;
      end
    end else begin
      bus.ptick = 1'b1;
    end
    bus.frame_ready = fr;
  endtask

  task automatic steps(input int n);
    repeat (n) step(1'b0);
  endtask

  logic [15:0] cw [3] = '{16'hF800, 16'h07E0, 16'h0841};
  logic [23:0] cx [3] = '{24'hFF0000, 24'h00FF00, 24'h080808};

  initial begin
    #(20 * 20000);
    $display("FAIL watchdog: cycle budget expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.xpos = '0; bus.ypos = '0; bus.ptick = 1'b0; bus.frame_ready = 1'b0;
    bus.pattern_en = 1'b0; ovr_en = 1'b0; ovr_word = '0;

    // reset state
    @(negedge clk); b = cyc;
    expect_at(b + 1, 0, 0); expect_at(b + 1, 1, 0);
    expect_at(b + 1, 2, 0); expect_at(b + 1, 3, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // address sequence from the top-left, word = pixel index
    set_pos(0, 0, b);
    addr_at(b, 0, 1); addr_at(b, 1, 1); addr_at(b, 2, 2); addr_at(b, 3, 2);
    pix_at(b, 0, 24'h000008); pix_at(b, 1, 24'h000008); pix_at(b, 2, 24'h000010);
    steps(16);

    // line wrap: fetch moves to x=0 of line 10 -> row 5
    set_pos(798, 9, b);
    addr_at(b, 0, 1600); addr_at(b, 1, 1600); addr_at(b, 2, 1601);
    pix_at(b, 0, 24'h00CB00);
    steps(12);

    // frame wrap: line 524 fetches line 0
    set_pos(798, 524, b);
    addr_at(b, 0, 0);
    steps(8);

    // last active line: valid up to fx=639, then held address and black
    ovr_en = 1'b1; ovr_word = 16'hF800;
    set_pos(636, 479, b);
    addr_at(b, 0, 76799); addr_at(b, 1, 76799); addr_at(b, 2, 76799);
    pix_at(b, 0, 24'hFF0000); pix_at(b, 1, 24'hFF0000);
    pix_at(b, 2, 24'h000000); pix_at(b, 3, 24'h000000);
    steps(16);

    // RGB565 expansion
    for (int i = 0; i < 3; i++) begin
      ovr_word = cw[i];
      set_pos(100, 50, b);
      pix_at(b, 0, cx[i]);
      steps(10);
    end
    ovr_en = 1'b0;

    // swap: two frame_ready pulses in one frame give a single swap
    set_pos(5, 100, b); step(1'b1); steps(3);
    set_pos(5, 200, b); step(1'b1); steps(3);
    set_pos(797, 480, b);
    expect_at(b + 5, 3, 0); expect_at(b + 6, 3, 1); expect_at(b + 7, 3, 0);
    expect_at(b + 5, 2, 0); expect_at(b + 6, 2, 1); expect_at(b + 7, 2, 1);
    steps(10);
    set_pos(797, 480, b);
    expect_at(b + 6, 3, 0); expect_at(b + 6, 2, 1);
    steps(10);
    set_pos(0, 0, b);
    addr_at(b, 0, 32'h20001);
    steps(8);

    // frame_ready on the swap edge re-arms for the next frame
    set_pos(5, 100, b); step(1'b1); steps(3);
    set_pos(799, 480, b); step(1'b1);
    expect_at(b + 2, 3, 1); expect_at(b + 2, 2, 0);
    steps(6);
    set_pos(799, 480, b);
    expect_at(b + 2, 3, 1); expect_at(b + 3, 3, 0); expect_at(b + 2, 2, 1);
    steps(6);

    // colour bars, RAM data ignored
    bus.pattern_en = 1'b1; ovr_en = 1'b1; ovr_word = 16'h1234;
    set_pos(125, 0, b);
    pix_at(b, 0, 24'hFFFFFF); pix_at(b, 1, 24'hFFFF00);
    steps(4); ovr_word = 16'hABCD; steps(8);
    set_pos(253, 0, b);
    pix_at(b, 0, 24'hFFFF00); pix_at(b, 1, 24'h00FFFF);
    steps(12);
    set_pos(382, 0, b);
    pix_at(b, 0, 24'h00FF00);
    steps(10);
    set_pos(637, 0, b);
    pix_at(b, 0, 24'hFF00FF); pix_at(b, 1, 24'h000000);
    steps(12);
    bus.pattern_en = 1'b0;

    // reset mid-line with a swap pending and bank 1 displayed
    ovr_word = 16'hF800;
    set_pos(300, 20, b); step(1'b1);
    pix_at(b, 0, 24'hFF0000);
    steps(9);
    @(negedge clk); reset = 1'b1; b = cyc;
    expect_at(b + 1, 0, 0); expect_at(b + 1, 1, 0);
    expect_at(b + 1, 2, 0); expect_at(b + 1, 3, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    set_pos(300, 20, b);
    expect_at(b + 4, 0, 0);
    pix_at(b, 0, 24'hFF0000);
    steps(10);
    set_pos(797, 480, b);
    expect_at(b + 6, 3, 0); expect_at(b + 6, 2, 0);
    steps(10);

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      $display("FAIL scoreboard: got %0d unchecked entries expected 0", sb.size());
      errors += sb.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
